// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with 2-entry queue; FETCH_STATS_EN adds stall/squash counters
module fetch_sequencer #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] code,
  output logic [PC_W-1:0]    code_pc,
  output logic               pc_fetch_done,
  input  logic               code_paser_back_pressure,
  input  logic               branch_valid,
  input  logic [PC_W-1:0]    branch_target
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]        stall_cycles,
  output logic [7:0]         squash_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_next;
  logic [1:0]         count;
  logic [1:0]         count_next;
  logic               rd_ptr;
  logic               wr_ptr;
  logic [INSTR_W-1:0] q_instr [2];
  logic [PC_W-1:0]    q_pc [2];
  logic               pop;
  logic               accept;
  logic               push;
  logic               pending_next;
  logic               can_issue;

  // Handshake qualifiers and next-cycle queue occupancy / PC.
  always_comb begin
    pop          = (count != 2'd0) && !code_paser_back_pressure;
    accept       = imem_req && imem_rdy;
    pending_next = imem_req && !imem_rdy;
    // Data returned while squashing, or in the same cycle as a redirect, is dropped.
    push         = accept && (state == FETCH) && !branch_valid;

    count_next = count;
    if (branch_valid) begin
      count_next = 2'd0;
    end else if (push && !pop) begin
      count_next = count + 2'd1;
    end else if (pop && !push) begin
      count_next = count - 2'd1;
    end

    pc_next = pc;
    if (branch_valid) begin
      pc_next = branch_target;
    end else if (push) begin
      pc_next = pc + PC_W'(1);
    end

    can_issue = (count_next != 2'd2);
  end

  assign pc_fetch_done = (count != 2'd0);
  assign code          = pc_fetch_done ? q_instr[rd_ptr] : '0;
  assign code_pc       = pc_fetch_done ? q_pc[rd_ptr]    : '0;

  // Fetch FSM: a pending request is held until accepted, otherwise the next one is issued from pc_next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      pc <= pc_next;
      if (pending_next) begin
        if (branch_valid) begin
          state <= SQUASH;
        end
      end else if (en) begin
        state     <= FETCH;
        imem_req  <= can_issue;
        imem_addr <= pc_next;
      end else begin
        state     <= IDLE;
        imem_req  <= 1'b0;
        imem_addr <= pc_next;
      end
    end
  end

  // Queue occupancy and pointers; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count <= count_next;
      if (branch_valid) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
      end
    end
  end

  // Queue storage; contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_data;
      q_pc[wr_ptr]    <= imem_addr;
    end
  end

`ifdef FETCH_STATS_EN
  logic discard;
  assign discard = accept && !push;

  // Saturating counters for parser stalls and discarded in-flight fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      squash_count <= '0;
    end else begin
      if (pc_fetch_done && code_paser_back_pressure && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (discard && (squash_count != 8'hFF)) begin
        squash_count <= squash_count + 8'd1;
      end
    end
  end
`endif

endmodule
